// File: rtl/pic_scheduler.sv
// Picture scheduler: commits button/auto-advance picture changes during vblank and handshakes with the loader.
// Optional macro PIC_SCHED_PINGPONG_EN makes auto-advance bounce between the ends instead of wrapping.
module pic_scheduler #(
    parameter logic [3:0]  TOTALPIC = 4'd13,
    parameter logic [23:0] DWELL    = 24'd16777215,
    parameter logic [15:0] LOAD_TO  = 16'd65535
) (
    input  logic       vgaclk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    input  logic       vblank,
    input  logic       load_ack,
    output logic [3:0] index,
    output logic       load_req,
    output logic       busy,
    output logic       load_err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PENDING  = 2'd1;
    localparam logic [1:0] LOAD     = 2'd2;
    localparam logic [3:0] LAST_IDX = TOTALPIC - 4'd1;

    logic [1:0]  state_r;
    logic [3:0]  index_r;
    logic [3:0]  target_r;
    logic        load_req_r;
    logic        load_err_r;
    logic [23:0] dwell_cnt_r;
    logic [15:0] to_cnt_r;
    logic        btn_req_s;
    logic [3:0]  btn_tgt_s;
    logic        auto_req_s;
    logic [3:0]  auto_tgt_s;
    logic        auto_win_s;
`ifdef PIC_SCHED_PINGPONG_EN
    logic        dir_fwd_r;
    logic        dir_fwd_nxt_s;
`endif

    assign index    = index_r;
    assign load_req = load_req_r;
    assign load_err = load_err_r;
    assign busy     = (state_r != IDLE);

    // Decode a single-button request; simultaneous presses cancel out.
    always_comb begin
        btn_req_s = 1'b0;
        btn_tgt_s = index_r;
        if (btn_next && !btn_prev) begin
            btn_req_s = 1'b1;
            btn_tgt_s = (index_r == LAST_IDX) ? 4'd0 : index_r + 4'd1;
        end else if (btn_prev && !btn_next) begin
            btn_req_s = 1'b1;
            btn_tgt_s = (index_r == 4'd0) ? LAST_IDX : index_r - 4'd1;
        end else begin
            btn_req_s = 1'b0;
        end
    end

    // Auto-advance request and its target under the selected direction policy.
    always_comb begin
        auto_req_s = auto_en && (dwell_cnt_r == DWELL - 24'd1);
        auto_tgt_s = index_r;
`ifdef PIC_SCHED_PINGPONG_EN
        dir_fwd_nxt_s = dir_fwd_r;
        if (dir_fwd_r) begin
            if (index_r == LAST_IDX) begin
                dir_fwd_nxt_s = 1'b0;
                auto_tgt_s    = TOTALPIC - 4'd2;
            end else begin
                auto_tgt_s = index_r + 4'd1;
            end
        end else begin
            if (index_r == 4'd0) begin
                dir_fwd_nxt_s = 1'b1;
                auto_tgt_s    = 4'd1;
            end else begin
                auto_tgt_s = index_r - 4'd1;
            end
        end
`else
        auto_tgt_s = (index_r == LAST_IDX) ? 4'd0 : index_r + 4'd1;
`endif
    end

    assign auto_win_s = auto_req_s && !btn_req_s;

    // Main FSM: request capture, vblank-aligned commit, loader handshake with timeout.
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            index_r    <= 4'd0;
            target_r   <= 4'd0;
            load_req_r <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (btn_req_s) begin
                        target_r <= btn_tgt_s;
                        state_r  <= PENDING;
                    end else if (auto_req_s) begin
                        target_r <= auto_tgt_s;
                        state_r  <= PENDING;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PENDING: begin
                    if (vblank) begin
                        index_r    <= target_r;
                        load_req_r <= 1'b1;
                        state_r    <= LOAD;
                    end else begin
                        state_r <= PENDING;
                    end
                end
                LOAD: begin
                    if (load_ack) begin
                        load_req_r <= 1'b0;
                        state_r    <= IDLE;
                    end else if (to_cnt_r == LOAD_TO - 16'd1) begin
                        load_req_r <= 1'b0;
                        load_err_r <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                default: begin
                    load_req_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    // Dwell counter: runs only while idle in cartoon mode, restarts on any departure from IDLE.
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt_r <= 24'd0;
        end else if ((state_r == IDLE) && auto_en && !btn_req_s && !auto_req_s) begin
            dwell_cnt_r <= dwell_cnt_r + 24'd1;
        end else begin
            dwell_cnt_r <= 24'd0;
        end
    end

    // Load timeout counter: cycles spent in LOAD waiting for the acknowledge.
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= 16'd0;
        end else if ((state_r == LOAD) && !load_ack && (to_cnt_r != LOAD_TO - 16'd1)) begin
            to_cnt_r <= to_cnt_r + 16'd1;
        end else begin
            to_cnt_r <= 16'd0;
        end
    end

`ifdef PIC_SCHED_PINGPONG_EN
    // Bounce direction only moves when an auto request actually wins arbitration.
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            dir_fwd_r <= 1'b1;
        end else if ((state_r == IDLE) && auto_win_s) begin
            dir_fwd_r <= dir_fwd_nxt_s;
        end else begin
            dir_fwd_r <= dir_fwd_r;
        end
    end
`endif

endmodule

// File: tb/tb_pic_scheduler.sv
// Self-checking bench for pic_scheduler: directed scenarios plus randomized transactions vs a transaction-level model.
module tb_pic_scheduler;

    localparam int N  = 13;
    localparam int DW = 8;
    localparam int LT = 16;

    logic       vgaclk;
    logic       rst_n;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic       vblank;
    logic       load_ack;
    logic [3:0] index;
    logic       load_req;
    logic       busy;
    logic       load_err;

    int checks;
    int fails;
    int idx_m;
    bit dir_fwd_m;
    bit err_m;

    pic_scheduler #(
        .TOTALPIC(4'd13),
        .DWELL   (24'd8),
        .LOAD_TO (16'd16)
    ) dut (
        .vgaclk  (vgaclk),
        .rst_n   (rst_n),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .auto_en (auto_en),
        .vblank  (vblank),
        .load_ack(load_ack),
        .index   (index),
        .load_req(load_req),
        .busy    (busy),
        .load_err(load_err)
    );

    initial vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    task automatic step();
        @(posedge vgaclk);
        #1;
    endtask

    function automatic int next_of(input int i);
        return (i + 1) % N;
    endfunction

    function automatic int prev_of(input int i);
        return (i + N - 1) % N;
    endfunction

    // Full button transaction with no checking; caller updates the model.
    task automatic do_btn(input bit nxt, input int pre, input int ack_dly);
        vblank = 1'b0;
        btn_next = nxt;
        btn_prev = !nxt;
        step();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (pre) step();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        repeat (ack_dly) step();
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (index !== 4'd0) begin fails++; $display("FAIL reset_index got=%0d exp=0", index); end
        checks++; if (load_req !== 1'b0) begin fails++; $display("FAIL reset_load_req got=%b exp=0", load_req); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (load_err !== 1'b0) begin fails++; $display("FAIL reset_load_err got=%b exp=0", load_err); end
    endtask

    task automatic test_next_basic();
        vblank = 1'b0;
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (index !== 4'd0 || load_req !== 1'b0) begin
                fails++; $display("FAIL basic_hold cyc=%0d index=%0d load_req=%b exp index=0 load_req=0", i, index, load_req);
            end
            step();
        end
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        checks++; if (index !== 4'd1) begin fails++; $display("FAIL basic_commit got=%0d exp=1", index); end
        checks++; if (load_req !== 1'b1) begin fails++; $display("FAIL basic_req got=%b exp=1", load_req); end
        repeat (2) step();
        checks++; if (load_req !== 1'b1) begin fails++; $display("FAIL basic_req_hold got=%b exp=1", load_req); end
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
        checks++; if (load_req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_ack load_req=%b busy=%b exp 0 0", load_req, busy);
        end
        idx_m = 1;
    endtask

    task automatic test_both_and_drop();
        btn_next = 1'b1;
        btn_prev = 1'b1;
        step();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        checks++; if (busy !== 1'b0 || index !== 4'(idx_m)) begin
            fails++; $display("FAIL both_ignored busy=%b index=%0d exp busy=0 index=%0d", busy, index, idx_m);
        end
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        vblank = 1'b1;
        step();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        step();
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
        idx_m = next_of(idx_m);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b0 || index !== 4'(idx_m)) begin
                fails++; $display("FAIL drop_in_load cyc=%0d busy=%b index=%0d exp busy=0 index=%0d", i, busy, index, idx_m);
            end
            step();
        end
        vblank = 1'b0;
    endtask

    task automatic test_wrap();
        while (idx_m != 0) begin
            do_btn(1'b0, 1, 1);
            idx_m = prev_of(idx_m);
        end
        checks++; if (index !== 4'd0) begin fails++; $display("FAIL wrap_start got=%0d exp=0", index); end
        do_btn(1'b0, 2, 3);
        idx_m = prev_of(idx_m);
        checks++; if (index !== 4'd12) begin fails++; $display("FAIL wrap_prev got=%0d exp=12", index); end
        do_btn(1'b1, 0, 0);
        idx_m = next_of(idx_m);
        checks++; if (index !== 4'd0) begin fails++; $display("FAIL wrap_next got=%0d exp=0", index); end
    endtask

    task automatic test_auto();
        int idle_run;
        int ack_cd;
        int adv;
        int exp_i;
        logic [3:0] prev_idx;
        idle_run = 0;
        ack_cd = -1;
        adv = 0;
        prev_idx = index;
        vblank = 1'b1;
        auto_en = 1'b1;
        for (int cyc = 0; cyc < 1000 && adv < 26; cyc++) begin
            if (busy === 1'b0) idle_run++;
            if (index !== prev_idx) begin
`ifdef PIC_SCHED_PINGPONG_EN
                if (dir_fwd_m && idx_m == N - 1) dir_fwd_m = 1'b0;
                else if (!dir_fwd_m && idx_m == 0) dir_fwd_m = 1'b1;
                exp_i = dir_fwd_m ? idx_m + 1 : idx_m - 1;
`else
                exp_i = next_of(idx_m);
`endif
                checks++;
                if (index !== 4'(exp_i)) begin
                    fails++; $display("FAIL auto_index adv=%0d got=%0d exp=%0d", adv, index, exp_i);
                end
                checks++;
                if (idle_run != DW) begin
                    fails++; $display("FAIL auto_spacing adv=%0d got=%0d exp=%0d", adv, idle_run, DW);
                end
                idx_m = exp_i;
                prev_idx = index;
                idle_run = 0;
                adv++;
                ack_cd = 2;
            end
            load_ack = (ack_cd == 0);
            if (ack_cd >= 0) ack_cd--;
            step();
        end
        auto_en = 1'b0;
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
        vblank = 1'b0;
        checks++; if (adv != 26) begin fails++; $display("FAIL auto_timeout got=%0d exp=26 advances", adv); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL auto_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_timeout();
        int n;
        vblank = 1'b0;
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        idx_m = next_of(idx_m);
        n = 0;
        while (load_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        err_m = 1'b1;
        checks++; if (n != LT) begin fails++; $display("FAIL timeout_len got=%0d exp=%0d", n, LT); end
        checks++; if (load_err !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL timeout_flags load_err=%b busy=%b exp 1 0", load_err, busy);
        end
        checks++; if (index !== 4'(idx_m)) begin fails++; $display("FAIL timeout_index got=%0d exp=%0d", index, idx_m); end
        do_btn(1'b1, 1, 2);
        idx_m = next_of(idx_m);
        checks++; if (index !== 4'(idx_m) || load_err !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL timeout_recover index=%0d load_err=%b busy=%b exp %0d 1 0", index, load_err, busy, idx_m);
        end
    endtask

    task automatic test_random();
        bit nxt;
        int pre;
        int dly;
        for (int t = 0; t < 30; t++) begin
            nxt = 1'($urandom_range(0, 1));
            pre = int'($urandom_range(0, 5));
            dly = int'($urandom_range(0, 12));
            vblank = 1'b0;
            btn_next = nxt;
            btn_prev = !nxt;
            step();
            for (int i = 0; i < pre; i++) begin
                btn_next = 1'($urandom_range(0, 1));
                btn_prev = 1'($urandom_range(0, 1));
                load_ack = 1'($urandom_range(0, 1));
                step();
            end
            btn_next = 1'b0;
            btn_prev = 1'b0;
            load_ack = 1'b0;
            idx_m = nxt ? next_of(idx_m) : prev_of(idx_m);
            vblank = 1'b1;
            step();
            vblank = 1'($urandom_range(0, 1));
            checks++;
            if (index !== 4'(idx_m) || load_req !== 1'b1) begin
                fails++; $display("FAIL rand_commit t=%0d index=%0d load_req=%b exp %0d 1", t, index, load_req, idx_m);
            end
            for (int i = 0; i < dly; i++) begin
                btn_next = 1'($urandom_range(0, 1));
                btn_prev = 1'($urandom_range(0, 1));
                step();
            end
            btn_next = 1'b0;
            btn_prev = 1'b0;
            checks++;
            if (load_req !== 1'b1 || index !== 4'(idx_m)) begin
                fails++; $display("FAIL rand_hold t=%0d load_req=%b index=%0d exp 1 %0d", t, load_req, index, idx_m);
            end
            load_ack = 1'b1;
            step();
            load_ack = 1'b0;
            checks++;
            if (load_req !== 1'b0 || busy !== 1'b0 || load_err !== err_m) begin
                fails++; $display("FAIL rand_done t=%0d load_req=%b busy=%b load_err=%b exp 0 0 %b", t, load_req, busy, load_err, err_m);
            end
        end
        vblank = 1'b0;
    endtask

    task automatic test_async_reset();
        do_btn(idx_m != N - 1, 0, 0);
        btn_next = (idx_m != N - 1);
        btn_prev = (idx_m == N - 1);
        step();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (load_req !== 1'b0 || index !== 4'd0 || load_err !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL async_reset load_req=%b index=%0d load_err=%b busy=%b exp 0 0 0 0", load_req, index, load_err, busy);
        end
        idx_m = 0;
        dir_fwd_m = 1'b1;
        err_m = 1'b0;
        #1;
        rst_n = 1'b1;
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL post_reset_accept busy=%b exp=1", busy); end
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        idx_m = 1;
        checks++; if (index !== 4'd1 || load_req !== 1'b1) begin
            fails++; $display("FAIL post_reset_commit index=%0d load_req=%b exp 1 1", index, load_req);
        end
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
        checks++; if (busy !== 1'b0 || load_req !== 1'b0) begin
            fails++; $display("FAIL post_reset_done busy=%b load_req=%b exp 0 0", busy, load_req);
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        idx_m = 0;
        dir_fwd_m = 1'b1;
        err_m = 1'b0;
        rst_n = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        auto_en = 1'b0;
        vblank = 1'b0;
        load_ack = 1'b0;
        repeat (3) step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_reset();
        test_next_basic();
        test_both_and_drop();
        test_wrap();
        test_auto();
        test_timeout();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
